xbus_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that acts as an xbus slave. It sits directly downstream of the RV32I core's xbus master port.
- Core stores push bytes into a TX FIFO. A serialiser drives 8N1 frames on txd at a programmable baud divisor.
- Status and divisor are readable with zero-latency combinational rdata, as the core's multi-cycle fetch/execute timing requires.

---
 rtl/xbus_uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_xbus_uart_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the xbus, with a TX FIFO and a programmable baud divisor.
// Latency: register reads are combinational; txd falls one clock after the push or enable write lands.
// Backpressure: none; a push into a full FIFO is dropped and sets the sticky ovf flag.
module xbus_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RST   = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xbus_as,
  input  logic        xbus_we,
  input  logic [3:0]  xbus_be,
  input  logic [31:0] xbus_addr,
  input  logic [31:0] xbus_wdata,
  output logic [31:0] xbus_rdata,
  output logic        txd,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_nxt;
  logic [15:0]    baud_cnt, baud_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic [7:0]     shift, shift_nxt;
  logic           txd_nxt;
  logic           pop;
  logic           bit_end;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty;
  logic           ovf;
  logic [15:0]    div;
  logic           tx_en, irq_en;

  logic           hit;
  logic [1:0]     sel;
  logic           wr_txdata, wr_status, wr_div, wr_ctrl;
  logic           push_ok, push_drop;

  // Address decode: one 16-byte window, word-selected by addr[3:2].
  assign hit       = xbus_as && (xbus_addr[31:4] == BASE_ADDR[31:4]);
  assign sel       = xbus_addr[3:2];
  assign wr_txdata = hit && xbus_we && (sel == 2'd0) && xbus_be[0];
  assign wr_status = hit && xbus_we && (sel == 2'd1);
  assign wr_div    = hit && xbus_we && (sel == 2'd2);
  assign wr_ctrl   = hit && xbus_we && (sel == 2'd3) && xbus_be[0];

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // Full is judged on the registered count, so a pop in the same cycle does not rescue a push.
  assign push_ok   = wr_txdata && !full;
  assign push_drop = wr_txdata && full;

  assign bit_end   = (baud_cnt >= div);

  // Combinational read mux; reads have no side effects.
  always_comb begin
    xbus_rdata = '0;
    if (hit && !xbus_we) begin
      case (sel)
        2'd1:    xbus_rdata = {16'h0000, 8'(count), 4'h0, ovf, (state != IDLE), empty, full};
        2'd2:    xbus_rdata = {16'h0000, div};
        2'd3:    xbus_rdata = {30'h0, irq_en, tx_en};
        default: xbus_rdata = '0;
      endcase
    end
  end

  // Control and status registers written from the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= DIV_RST;
      tx_en  <= 1'b1;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_div && xbus_be[0]) div[7:0]  <= xbus_wdata[7:0];
      if (wr_div && xbus_be[1]) div[15:8] <= xbus_wdata[15:8];
      if (wr_ctrl) begin
        tx_en  <= xbus_wdata[0];
        irq_en <= xbus_wdata[1];
      end
      if (push_drop)
        ovf <= 1'b1;
      else if (wr_status && xbus_be[0] && xbus_wdata[3])
        ovf <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= xbus_wdata[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser next-state: bit timing, shifting, and back-to-back frame chaining from STOP.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = bit_end ? 16'd0 : baud_cnt + 16'd1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt    = 16'd0;
        bit_idx_nxt = 3'd0;
        if (!empty && tx_en) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty && tx_en) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Line level is derived from the next state so txd is a clean flop output.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  // Serialiser state register; reset abandons any frame in flight and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      txd      <= txd_nxt;
    end
  end

  // TX-done interrupt, registered one cycle behind the idle-and-drained condition.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= irq_en && empty && (state == IDLE);
  end

endmodule

// File: tb/tb_xbus_uart_tx.sv
// Directed bench for xbus_uart_tx: register access, frame timing, FIFO overflow, irq and reset.
// Inputs are driven from negedge-aligned tasks; outputs are sampled on the negedge.
// DUT is built with DEPTH=4 so the full/overflow corner is reached with few pushes.
module tb_xbus_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        xbus_as;
  logic        xbus_we;
  logic [3:0]  xbus_be;
  logic [31:0] xbus_addr;
  logic [31:0] xbus_wdata;
  logic [31:0] xbus_rdata;
  logic        txd;
  logic        irq;

  int checks = 0;
  int errors = 0;

  xbus_uart_tx #(
    .BASE_ADDR(BASE),
    .DEPTH(4),
    .DIV_RST(16'd867)
  ) dut (
    .clk(clk),
    .rst(rst),
    .xbus_as(xbus_as),
    .xbus_we(xbus_we),
    .xbus_be(xbus_be),
    .xbus_addr(xbus_addr),
    .xbus_wdata(xbus_wdata),
    .xbus_rdata(xbus_rdata),
    .txd(txd),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single write; lands on the next posedge, returns on the following negedge.
  task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [3:0] be);
    xbus_as    = 1'b1;
    xbus_we    = 1'b1;
    xbus_be    = be;
    xbus_addr  = BASE + 32'(off);
    xbus_wdata = data;
    @(posedge clk);
    @(negedge clk);
    xbus_as    = 1'b0;
    xbus_we    = 1'b0;
    xbus_be    = 4'h0;
    xbus_wdata = '0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    xbus_as   = 1'b1;
    xbus_we   = 1'b0;
    xbus_be   = 4'hF;
    xbus_addr = addr;
    #1;
    chk(tag, xbus_rdata, exp);
    xbus_as   = 1'b0;
    xbus_be   = 4'h0;
  endtask

  // Called on the negedge after the frame's first (START) edge; samples every bit-clock.
  task automatic check_frame(input logic [7:0] data, input int div, input logic [31:0] stat,
                             input string tag);
    logic [9:0] f;
    f = {1'b1, data, 1'b0};
    xbus_as   = 1'b1;
    xbus_we   = 1'b0;
    xbus_be   = 4'hF;
    xbus_addr = BASE + 32'h4;
    for (int i = 0; i < 10 * (div + 1); i++) begin
      #1;
      chk($sformatf("%s txd[%0d]", tag, i), {31'b0, txd}, {31'b0, f[i / (div + 1)]});
      chk($sformatf("%s status[%0d]", tag, i), xbus_rdata, stat);
      chk($sformatf("%s irq[%0d]", tag, i), {31'b0, irq}, 32'h0);
      @(negedge clk);
    end
    xbus_as = 1'b0;
    xbus_be = 4'h0;
  endtask

  initial begin
    rst = 1'b1; xbus_as = 1'b0; xbus_we = 1'b0; xbus_be = 4'h0;
    xbus_addr = '0; xbus_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and decode
    chk("rst txd", {31'b0, txd}, 32'h1);
    chk("rst irq", {31'b0, irq}, 32'h0);
    rd(BASE + 32'h4, 32'h0000_0002, "rst status");
    rd(BASE + 32'h8, 32'd867, "rst div");
    rd(BASE + 32'hC, 32'h0000_0001, "rst ctrl");
    @(negedge clk);
    rd(BASE + 32'h10, 32'h0, "unmapped read");
    rd(BASE + 32'h0, 32'h0, "txdata read");
    wr(4'h8, 32'h0000_AB12, 4'b0010);
    rd(BASE + 32'h8, 32'h0000_AB63, "div upper lane only");

    // DIV=3, single frame of 0x55
    @(negedge clk);
    wr(4'h8, 32'h0000_0003, 4'b0011);
    wr(4'h0, 32'h0000_0055, 4'b0001);
    chk("t2 txd before start", {31'b0, txd}, 32'h1);
    @(negedge clk);
    check_frame(8'h55, 3, 32'h0000_0006, "t2");
    chk("t2 txd idle", {31'b0, txd}, 32'h1);
    rd(BASE + 32'h4, 32'h0000_0002, "t2 status idle");

    // DIV=1, two queued bytes released together, frames contiguous
    @(negedge clk);
    wr(4'hC, 32'h0, 4'b0001);
    wr(4'h8, 32'h0000_0001, 4'b0011);
    wr(4'h0, 32'h0000_00A5, 4'b0001);
    wr(4'h0, 32'h0000_003C, 4'b0001);
    rd(BASE + 32'h4, 32'h0000_0200, "t3 count2");
    wr(4'hC, 32'h1, 4'b0001);
    chk("t3 txd before start", {31'b0, txd}, 32'h1);
    @(negedge clk);
    check_frame(8'hA5, 1, 32'h0000_0104, "t3a");
    check_frame(8'h3C, 1, 32'h0000_0006, "t3b");
    chk("t3 txd idle", {31'b0, txd}, 32'h1);
    rd(BASE + 32'h4, 32'h0000_0002, "t3 status idle");

    // Overflow with tx disabled, ovf clear, then drain; push while full and popping is dropped
    @(negedge clk);
    wr(4'hC, 32'h0, 4'b0001);
    wr(4'h0, 32'h11, 4'b0001);
    wr(4'h0, 32'h22, 4'b0001);
    wr(4'h0, 32'h33, 4'b0001);
    wr(4'h0, 32'h44, 4'b0001);
    wr(4'h0, 32'h55, 4'b0001);
    wr(4'h0, 32'h66, 4'b0001);
    rd(BASE + 32'h4, 32'h0000_0409, "t4 full ovf");
    wr(4'h4, 32'h0000_0008, 4'b0001);
    rd(BASE + 32'h4, 32'h0000_0401, "t4 ovf cleared");
    wr(4'hC, 32'h1, 4'b0001);
    wr(4'h0, 32'h77, 4'b0001);
    check_frame(8'h11, 1, 32'h0000_030C, "t4a");
    check_frame(8'h22, 1, 32'h0000_020C, "t4b");
    check_frame(8'h33, 1, 32'h0000_010C, "t4c");
    check_frame(8'h44, 1, 32'h0000_000E, "t4d");
    chk("t4 txd idle", {31'b0, txd}, 32'h1);
    rd(BASE + 32'h4, 32'h0000_000A, "t4 status idle");
    wr(4'h4, 32'h0000_0008, 4'b0001);
    rd(BASE + 32'h4, 32'h0000_0002, "t4 ovf cleared again");

    // irq behaviour at DIV=2
    @(negedge clk);
    wr(4'h8, 32'h0000_0002, 4'b0011);
    wr(4'hC, 32'h3, 4'b0001);
    chk("t5 irq lags enable", {31'b0, irq}, 32'h0);
    wr(4'h0, 32'h0F, 4'b0001);
    chk("t5 irq high", {31'b0, irq}, 32'h1);
    chk("t5 txd before start", {31'b0, txd}, 32'h1);
    @(negedge clk);
    check_frame(8'h0F, 2, 32'h0000_0006, "t5");
    chk("t5 irq first idle cycle", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("t5 irq after idle", {31'b0, irq}, 32'h1);

    // Reset during DATA, then a clean frame
    wr(4'hC, 32'h1, 4'b0001);
    wr(4'h0, 32'h00, 4'b0001);
    wr(4'h0, 32'hFF, 4'b0001);
    repeat (4) @(negedge clk);
    chk("t6 txd in data", {31'b0, txd}, 32'h0);
    rd(BASE + 32'h4, 32'h0000_0104, "t6 status in data");
    rst = 1'b1;
    @(negedge clk);
    chk("t6 txd after rst", {31'b0, txd}, 32'h1);
    rd(BASE + 32'h4, 32'h0000_0002, "t6 status after rst");
    rd(BASE + 32'h8, 32'd867, "t6 div after rst");
    chk("t6 irq after rst", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    wr(4'h8, 32'h0000_0001, 4'b0011);
    wr(4'h0, 32'hC3, 4'b0001);
    chk("t6 txd before start", {31'b0, txd}, 32'h1);
    @(negedge clk);
    check_frame(8'hC3, 1, 32'h0000_0006, "t6");
    chk("t6 txd idle", {31'b0, txd}, 32'h1);
    rd(BASE + 32'h4, 32'h0000_0002, "t6 status idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
